result_packer: RTL

- Writer side of the CNN1 result local memory.
- Collects the final-layer output stream: per class, NUM_PART signed partial sums arrive one per handshake.
- Accumulates each class with saturation, packs all classes into one NUM_CLASS*DATA_W vector, and issues a single-cycle write strobe to the result memory.
- Sits between the last conv/FC stage and the result memory; signals completion to the CNN controller.

---
 rtl/result_packer.sv | 95 +++++++++
 1 files changed

// File: rtl/result_packer.sv
// Writer side of the CNN1 result memory: accumulates NUM_PART signed partial sums per
// class with saturation, packs NUM_CLASS scores and issues one write strobe per run.
module result_packer #(
  parameter int NUM_CLASS = 10,
  parameter int DATA_W    = 16,
  parameter int NUM_PART  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        score_valid,
  input  logic signed [DATA_W-1:0]    score_data,
  output logic                        score_ready,
  output logic [NUM_CLASS*DATA_W-1:0] write_result_data,
  output logic                        write_result_signal,
  output logic                        busy,
  output logic                        done
);

  localparam int PW = (NUM_PART > 1) ? $clog2(NUM_PART) : 1;
  localparam int CW = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1;
  localparam logic [PW-1:0] PART_LAST  = PW'(NUM_PART - 1);
  localparam logic [CW-1:0] CLASS_LAST = CW'(NUM_CLASS - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic [PW-1:0]            part_cnt;
  logic [CW-1:0]            class_cnt;
  logic signed [DATA_W-1:0] acc [NUM_CLASS];
  logic                     accept;
  logic                     last_beat;

  // Add at DATA_W+1 bits; disagreeing top bits mean the DATA_W result overflowed.
  function automatic logic signed [DATA_W-1:0] sat_add(input logic signed [DATA_W-1:0] a,
                                                       input logic signed [DATA_W-1:0] b);
    logic signed [DATA_W:0] sum;
    sum = (DATA_W+1)'(a) + (DATA_W+1)'(b);
    if (sum[DATA_W] != sum[DATA_W-1])
      sat_add = sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    else
      sat_add = sum[DATA_W-1:0];
  endfunction

  assign score_ready         = (state == COLLECT);
  assign write_result_signal = (state == WRITE);
  assign done                = (state == DONE);
  assign busy                = (state != IDLE);
  assign accept              = score_valid && score_ready;
  assign last_beat           = (class_cnt == CLASS_LAST) && (part_cnt == PART_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = COLLECT;
      COLLECT: if (accept && last_beat) state_nxt = WRITE;
      WRITE:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      part_cnt  <= '0;
      class_cnt <= '0;
      for (int k = 0; k < NUM_CLASS; k++) acc[k] <= '0;
    end else if (state == IDLE && start) begin
      part_cnt  <= '0;
      class_cnt <= '0;
      for (int k = 0; k < NUM_CLASS; k++) acc[k] <= '0;
    end else if (accept) begin
      for (int k = 0; k < NUM_CLASS; k++)
        if (class_cnt == CW'(k)) acc[k] <= sat_add(acc[k], score_data);
      if (part_cnt == PART_LAST) begin
        part_cnt  <= '0;
        class_cnt <= class_cnt + 1'b1;
      end else begin
        part_cnt  <= part_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    write_result_data = '0;
    for (int k = 0; k < NUM_CLASS; k++) write_result_data[DATA_W*k +: DATA_W] = acc[k];
  end

endmodule
